// File: rtl/noc_flit_mux2.sv
// Registered 2:1 NoC flit multiplexer with one-hot select and an optional
// packet-lock mode that holds the chosen port from a HEAD flit until its TAIL.
module noc_flit_mux2 #(
  parameter int unsigned DATA_W  = 66,
  parameter int unsigned VCH_W   = 2,
  parameter int unsigned SEL_W   = 5,
  parameter bit          LOCK_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
);

  localparam int unsigned TYPE_W = 2;
  localparam logic [TYPE_W-1:0] TYPE_HEAD = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_TAIL = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              lock_port_q, lock_port_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic [VCH_W-1:0]  ovch_q, ovch_d;

  logic              port_act;
  logic              port_idx;
  logic [DATA_W-1:0] pick_data;
  logic              pick_valid;
  logic [VCH_W-1:0]  pick_vch;
  logic [TYPE_W-1:0] pick_type;

  // Select bits above [1:0] carry no meaning for a two-port mux.
  logic unused_sel_c;
  assign unused_sel_c = ^sel[SEL_W-1:2];

  // Effective port, then next-state and output-register loads.
  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    port_act    = 1'b0;
    port_idx    = 1'b0;
    odata_d     = '0;
    ovalid_d    = 1'b0;
    ovch_d      = '0;

    if (LOCK_EN && (state_q == ST_LOCKED)) begin
      port_act = 1'b1;
      port_idx = lock_port_q;
    end else if (sel[0]) begin
      port_act = 1'b1;
      port_idx = 1'b0;
    end else if (sel[1]) begin
      port_act = 1'b1;
      port_idx = 1'b1;
    end

    pick_data  = port_idx ? idata_1  : idata_0;
    pick_valid = port_idx ? ivalid_1 : ivalid_0;
    pick_vch   = port_idx ? ivch_1   : ivch_0;
    pick_type  = pick_data[DATA_W-1 -: TYPE_W];

    if (port_act) begin
      odata_d  = pick_data;
      ovalid_d = pick_valid;
      ovch_d   = pick_vch;
    end

    if (LOCK_EN && port_act && pick_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_type == TYPE_HEAD) begin
            state_d     = ST_LOCKED;
            lock_port_d = port_idx;
          end
        end
        ST_LOCKED: begin
          if (pick_type == TYPE_TAIL) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (!LOCK_EN) begin
      state_d     = ST_IDLE;
      lock_port_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_port_q <= 1'b0;
      odata_q     <= '0;
      ovalid_q    <= 1'b0;
      ovch_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      odata_q     <= odata_d;
      ovalid_q    <= ovalid_d;
      ovch_q      <= ovch_d;
    end
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;

endmodule

// File: tb/tb_noc_flit_mux2.sv
// Bench for noc_flit_mux2: one free-running and one packet-locking instance
// driven in parallel and checked against a packet-level reference model.
module tb_noc_flit_mux2;

  localparam int unsigned DATA_W = 66;
  localparam int unsigned VCH_W  = 2;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned OUT_W  = DATA_W + 1 + VCH_W;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] d0, d1;
  logic              v0, v1;
  logic [VCH_W-1:0]  c0, c1;
  logic [SEL_W-1:0]  sel;

  logic [DATA_W-1:0] o0_data, o1_data;
  logic              o0_valid, o1_valid;
  logic [VCH_W-1:0]  o0_vch, o1_vch;

  logic [OUT_W-1:0] act0, act1, exp0, exp1;
  int lk;
  int nchk = 0;
  int nerr = 0;

  assign act0 = {o0_data, o0_valid, o0_vch};
  assign act1 = {o1_data, o1_valid, o1_vch};

  always #5 clk = ~clk;

  noc_flit_mux2 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W), .LOCK_EN(1'b0)) u_free (
    .clk(clk), .rst(rst),
    .idata_0(d0), .ivalid_0(v0), .ivch_0(c0),
    .idata_1(d1), .ivalid_1(v1), .ivch_1(c1),
    .sel(sel),
    .odata(o0_data), .ovalid(o0_valid), .ovch(o0_vch)
  );

  noc_flit_mux2 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W), .LOCK_EN(1'b1)) u_lock (
    .clk(clk), .rst(rst),
    .idata_0(d0), .ivalid_0(v0), .ivch_0(c0),
    .idata_1(d1), .ivalid_1(v1), .ivch_1(c1),
    .sel(sel),
    .odata(o1_data), .ovalid(o1_valid), .ovch(o1_vch)
  );

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input logic [63:0] p);
    return {t, p};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [OUT_W-1:0] port_flit(input int p);
    if (p == 0) return {d0, v0, c0};
    if (p == 1) return {d1, v1, c1};
    return '0;
  endfunction

  // Packet-level model: which port owns the output, and whether a packet holds it.
  task automatic step();
    int want, use_p;
    logic [OUT_W-1:0] f;
    logic [1:0] t;
    if (rst) begin
      exp0 = '0;
      exp1 = '0;
      lk   = -1;
    end else begin
      want  = sel[0] ? 0 : (sel[1] ? 1 : -1);
      exp0  = port_flit(want);
      use_p = (lk >= 0) ? lk : want;
      f     = port_flit(use_p);
      exp1  = f;
      t     = f[OUT_W-1 -: 2];
      if (use_p >= 0 && f[VCH_W]) begin
        if (lk < 0 && t == T_HEAD) lk = use_p;
        else if (lk >= 0 && t == T_TAIL) lk = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 5'b00011;
    d0 = mk(T_DATA, rnd64()); v0 = 1'b1; c0 = 2'd1;
    d1 = mk(T_DATA, rnd64()); v1 = 1'b1; c1 = 2'd3;
    lk = -1;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (act0 !== '0) begin nerr++; $display("FAIL reset_free got=%h want=0", act0); end
    nchk++;
    if (act1 !== '0) begin nerr++; $display("FAIL reset_lock got=%h want=0", act1); end
    rst = 1'b0;
    step();
    nchk++;
    if (act0 !== exp0 || act0 !== {d0, v0, c0}) begin
      nerr++; $display("FAIL reset_release_free got=%h want=%h", act0, exp0);
    end
    nchk++;
    if (act1 !== exp1) begin nerr++; $display("FAIL reset_release_lock got=%h want=%h", act1, exp1); end
  endtask

  task automatic test_port1_stream();
    sel = 5'b00010;
    for (int i = 0; i < 22; i++) begin
      d1 = (i == 0) ? mk(T_HEAD, 64'h4) : mk((i == 21) ? T_TAIL : T_DATA, rnd64());
      v1 = 1'b1; c1 = 2'd2;
      d0 = mk(T_DATA, rnd64()); v0 = 1'b1; c0 = 2'd1;
      step();
      nchk++;
      if (act0 !== exp0 || o0_vch !== 2'd2 || o0_data !== d1) begin
        nerr++; $display("FAIL port1_free[%0d] got=%h want=%h", i, act0, exp0);
      end
      nchk++;
      if (act1 !== exp1 || o1_data !== d1) begin
        nerr++; $display("FAIL port1_lock[%0d] got=%h want=%h", i, act1, exp1);
      end
    end
  endtask

  task automatic test_port0_select();
    logic [1:0] seq [3];
    logic [SEL_W-1:0] sels [3];
    seq[0] = T_HEAD; seq[1] = T_DATA; seq[2] = T_TAIL;
    sels[0] = 5'b00001; sels[1] = 5'b00011; sels[2] = 5'b00011;
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      d0 = (i == 0) ? mk(T_HEAD, 64'h9) : mk(seq[i], rnd64()); v0 = 1'b1; c0 = 2'(i);
      d1 = mk(T_HEAD, rnd64()); v1 = 1'b1; c1 = 2'd3;
      step();
      nchk++;
      if (act0 !== exp0 || o0_data !== d0) begin
        nerr++; $display("FAIL port0_free[%0d] got=%h want=%h", i, act0, exp0);
      end
      nchk++;
      if (act1 !== exp1) begin nerr++; $display("FAIL port0_lock[%0d] got=%h want=%h", i, act1, exp1); end
    end
  endtask

  task automatic test_no_select();
    logic [SEL_W-1:0] sels [2];
    sels[0] = 5'b00000; sels[1] = 5'b11100;
    for (int i = 0; i < 2; i++) begin
      sel = sels[i];
      d0 = mk(T_DATA, rnd64()); v0 = 1'b1; c0 = 2'd1;
      d1 = mk(T_DATA, rnd64()); v1 = 1'b1; c1 = 2'd2;
      step();
      nchk++;
      if (act0 !== '0 || exp0 !== '0) begin
        nerr++; $display("FAIL nosel_free[%0d] got=%h want=0", i, act0);
      end
      nchk++;
      if (act1 !== exp1) begin nerr++; $display("FAIL nosel_lock[%0d] got=%h want=%h", i, act1, exp1); end
    end
  endtask

  task automatic test_lock_hold();
    for (int i = 0; i < 8; i++) begin
      sel = (i == 0) ? 5'b00001 : 5'b00010;
      d0 = mk((i == 0) ? T_HEAD : ((i == 6) ? T_TAIL : T_DATA), rnd64()); v0 = 1'b1; c0 = 2'd1;
      d1 = mk(T_DATA, rnd64()); v1 = 1'b1; c1 = 2'd2;
      step();
      nchk++;
      if (act1 !== exp1 || o1_data !== ((i <= 6) ? d0 : d1)) begin
        nerr++; $display("FAIL lock_hold[%0d] got=%h want=%h", i, act1, exp1);
      end
      nchk++;
      if (act0 !== exp0) begin nerr++; $display("FAIL lock_free[%0d] got=%h want=%h", i, act0, exp0); end
    end
  endtask

  task automatic test_reset_mid_packet();
    sel = 5'b00001;
    d0 = mk(T_HEAD, rnd64()); v0 = 1'b1; c0 = 2'd3;
    d1 = mk(T_DATA, rnd64()); v1 = 1'b1; c1 = 2'd2;
    step();
    d0 = mk(T_DATA, rnd64());
    step();
    #2;
    rst = 1'b1;
    #1;
    nchk++;
    if (act1 !== '0) begin nerr++; $display("FAIL midrst_async got=%h want=0", act1); end
    step();
    rst = 1'b0;
    sel = 5'b00010;
    d1 = mk(T_DATA, rnd64());
    step();
    nchk++;
    if (act1 !== exp1 || o1_data !== d1 || o1_vch !== 2'd2) begin
      nerr++; $display("FAIL midrst_port1 got=%h want=%h", act1, exp1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sel = SEL_W'($urandom);
      d0 = mk(2'($urandom), rnd64()); v0 = 1'($urandom); c0 = VCH_W'($urandom);
      d1 = mk(2'($urandom), rnd64()); v1 = 1'($urandom); c1 = VCH_W'($urandom);
      step();
      nchk++;
      if (act0 !== exp0) begin nerr++; $display("FAIL rand_free[%0d] got=%h want=%h", i, act0, exp0); end
      nchk++;
      if (act1 !== exp1) begin nerr++; $display("FAIL rand_lock[%0d] got=%h want=%h", i, act1, exp1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = '0;
    d0 = mk(T_NONE, 64'h0); v0 = 1'b0; c0 = '0;
    d1 = mk(T_NONE, 64'h0); v1 = 1'b0; c1 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_port1_stream();
    test_port0_select();
    test_no_select();
    test_lock_hold();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/noc_flit_mux2.md
Name: noc_flit_mux2

Overview:
- Registered 2:1 flit multiplexer for the NoC router datapath.
- Forwards one of two input ports (data, valid, virtual channel) to a single output port, chosen by a one-hot select.
- Sits between the router input buffers and an output link.
- Optional packet-lock mode keeps the selection fixed from HEAD flit to TAIL flit.

Parameters:
- DATA_W, 66, flit width. Bits [DATA_W-1:DATA_W-2] are the flit type; the remaining 64 bits are payload.
- VCH_W, 2, virtual-channel id width.
- SEL_W, 5, one-hot select width. Only bits [1:0] are meaningful; upper bits are ignored.
- LOCK_EN, 0, 1 = hold the selection for the whole packet (HEAD..TAIL); 0 = select is honoured every cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- idata_0  in  DATA_W  port-0 flit.
- ivalid_0  in  1  port-0 flit valid.
- ivch_0  in  VCH_W  port-0 virtual channel.
- idata_1  in  DATA_W  port-1 flit.
- ivalid_1  in  1  port-1 flit valid.
- ivch_1  in  VCH_W  port-1 virtual channel.
- sel  in  SEL_W  one-hot select: bit0 = port 0, bit1 = port 1.
- odata  out  DATA_W  selected flit.
- ovalid  out  1  selected valid.
- ovch  out  VCH_W  selected virtual channel.

Behaviour:
- Type encoding (top 2 bits): NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
- Reset: while rst is high, odata=0, ovalid=0, ovch=0, and the lock FSM is in IDLE with lock_port=0. Reset is asynchronous: outputs clear immediately, not at the next edge.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N. Outputs are registered; there is no combinational path from inputs to outputs.
- Effective select (LOCK_EN=0 or FSM in IDLE):
  - sel[0]=1 -> port 0 (port 0 wins if sel[1:0]=2'b11).
  - sel[1:0]=2'b10 -> port 1.
  - sel[1:0]=2'b00 -> no port. Output registers load odata=0, ovalid=0, ovch=0.
  - sel[SEL_W-1:2] is ignored.
- With a port selected, odata, ovalid and ovch are copied as a group from that port. Data is forwarded even when valid=0, so the output mirrors the input exactly.
- Lock FSM (only when LOCK_EN=1):
  - IDLE: if the effective port has valid=1 and type=HEAD, capture that port into lock_port and go to LOCKED. The HEAD flit itself is forwarded this cycle.
  - LOCKED: ignore sel and forward lock_port. When lock_port has valid=1 and type=TAIL, forward that flit and return to IDLE.
  - HEAD followed directly by TAIL is legal.
  - A HEAD arriving on lock_port while LOCKED is forwarded; the FSM stays LOCKED.
  - Invalid flits never change state.
- When LOCK_EN=0, the FSM is held in IDLE.
- Reset mid-packet returns the FSM to IDLE and clears the outputs. The next HEAD restarts locking.
- No backpressure, no buffering, no arithmetic on the flit.

Test Plan:
- Reset: hold rst=1 while inputs are non-zero -> odata=0, ovalid=0, ovch=0. Deassert rst -> outputs follow the selected port one cycle later.
- sel=5'b00010, port 1 sends HEAD {2'b01,32'h0,32'h4}, 20 DATA flits, then TAIL, valid=1, vch=2; port 0 sends different traffic -> output equals the port-1 sequence delayed by one cycle, with ovch=2 and port-0 traffic never appearing.
- sel=5'b00001 -> output carries the port-0 HEAD {2'b01,32'h0,32'h9} one cycle later. Set sel=5'b00011 -> port 0 still wins.
- sel=5'b00000 with both ports valid -> ovalid=0, odata=0. sel=5'b11100 -> same result, since upper bits are ignored.
- LOCK_EN=1: port 0 sends HEAD, then sel switches to 5'b00010 mid-packet -> port 0 flits continue through TAIL. The first flit after TAIL comes from port 1.
- LOCK_EN=1: assert rst during LOCKED -> outputs clear immediately. After release, sel=5'b00010 selects port 1 at once.
